// File: rtl/dpi_stream_bridge.sv
// dpi_stream_bridge: accepted beats are evaluated by the model at the clock edge, delayed LATENCY stages, then queued in an output FIFO.
// Macros: DPI_BRIDGE_STATS_EN adds the stat_* counters; the model is a built-in r = d + 1 stand-in.
module dpi_stream_bridge #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
`ifdef DPI_BRIDGE_STATS_EN
    ,
    output logic [31:0]       stat_acc,
    output logic [31:0]       stat_emit,
    output logic [31:0]       stat_stall
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(LATENCY + 1);
    localparam int unsigned ENT_W = OUT_W + TAG_W;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("dpi_stream_bridge: LATENCY=%0d outside 1..8", LATENCY);
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dpi_stream_bridge: FIFO_DEPTH=%0d must be a power of two in 2..64", FIFO_DEPTH);
    end

    // Stand-in model: r = d + 1, with a call counter.
    int unsigned eval_calls = 0;
    int unsigned unused_scope_len;
    logic        unused_calls;

    function automatic chandle create_model(input string scope);
        unused_scope_len = scope.len();
        return null;
    endfunction

    function automatic void eval_step(input chandle unused_h, input bit [TAG_W-1:0] unused_tag,
                                      input bit [IN_W-1:0] d, output bit [OUT_W-1:0] r);
        r          = OUT_W'(d) + OUT_W'(1);
        eval_calls = eval_calls + 1;
    endfunction

    function automatic void final_model(input chandle unused_h);
    endfunction

`ifdef DPI_BRIDGE_STATS_EN
    function automatic void final_model_stats(input chandle unused_h, input bit [31:0] unused_acc,
                                              input bit [31:0] unused_emit, input bit [31:0] unused_stall);
    endfunction
`endif

    assign unused_calls = ^eval_calls;

    chandle model_h;

    initial model_h = create_model($sformatf("%m"));

    // One model evaluation per accepted beat; only called on an accept.
    function automatic logic [OUT_W-1:0] run_model(input logic [TAG_W-1:0] tag, input logic [IN_W-1:0] d);
        bit [OUT_W-1:0] r;
        eval_step(model_h, tag, d, r);
        return r;
    endfunction

    logic                accept;
    logic                pop;
    logic                push;
    logic [LATENCY-1:0]  stg_valid;
    logic [OUT_W-1:0]    stg_data [LATENCY];
    logic [TAG_W-1:0]    stg_tag  [LATENCY];
    logic [TAG_W-1:0]    tag_q;
    logic [ENT_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [INF_W-1:0]    inflight_q, inflight_d;
    logic [ENT_W-1:0]    head_d;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign push   = stg_valid[LATENCY-1];

    // Result pipeline: never stalls; the credit check keeps the FIFO from overflowing.
    always_ff @(posedge clk or negedge rst_n) begin : p_pipe
        if (!rst_n) begin
            stg_valid <= '0;
            tag_q     <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stg_data[i] <= '0;
                stg_tag[i]  <= '0;
            end
        end else begin
            stg_valid[0] <= accept;
            if (accept) begin
                stg_data[0] <= run_model(tag_q, in_data);
                stg_tag[0]  <= tag_q;
                tag_q       <= tag_q + TAG_W'(1);
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_data[i]  <= stg_data[i-1];
                stg_tag[i]   <= stg_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin : p_mem
        if (push) begin
            mem[wr_q] <= {stg_tag[LATENCY-1], stg_data[LATENCY-1]};
        end
    end

    // Next FIFO/credit state; a push into an emptying FIFO bypasses the memory to the head.
    always_comb begin : p_next
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d = inflight_q + INF_W'(accept) - INF_W'(push);
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        head_d = mem[rd_d];
        if (push && count_q == CNT_W'(pop)) begin
            head_d = {stg_tag[LATENCY-1], stg_data[LATENCY-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            in_ready   <= (32'(count_d) + 32'(inflight_d)) < FIFO_DEPTH;
            out_valid  <= count_d != '0;
            busy       <= (count_d != '0) || (inflight_d != '0);
            if (count_d != '0) begin
                {out_tag, out_data} <= head_d;
            end
        end
    end

`ifdef DPI_BRIDGE_STATS_EN
    // Saturating activity counters, reported to the model at end of simulation.
    always_ff @(posedge clk or negedge rst_n) begin : p_stats
        if (!rst_n) begin
            stat_acc   <= '0;
            stat_emit  <= '0;
            stat_stall <= '0;
        end else begin
            if (accept && stat_acc != 32'hFFFF_FFFF) begin
                stat_acc <= stat_acc + 32'd1;
            end
            if (pop && stat_emit != 32'hFFFF_FFFF) begin
                stat_emit <= stat_emit + 32'd1;
            end
            if (in_valid && !in_ready && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end

    final begin
        final_model_stats(model_h, stat_acc, stat_emit, stat_stall);
        final_model(model_h);
    end
`else
    final final_model(model_h);
`endif

endmodule
